// File: rtl/dff_pipe_family.sv
// Enable-gated delay chains with synchronous active-low clear: dff (vector),
// dff2 (1-D array), dff3 (2-D array), and a top wrapper exercising all three.

module dff #(
  parameter int WIDTH         = 1,
  parameter int PIPE_DEPTH    = 1,
  parameter int RETIME_STATUS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  if (PIPE_DEPTH == 0) begin : g_wire
    // No storage at zero depth; clock and controls are intentionally dropped.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign out = in;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [PIPE_DEPTH];
    logic [WIDTH-1:0] stage_d [PIPE_DEPTH];

    always_comb begin
      for (int k = 0; k < PIPE_DEPTH; k++) stage_d[k] = stage_q[k];
      if (!rst) begin
        for (int k = 0; k < PIPE_DEPTH; k++) stage_d[k] = '0;
      end else if (en) begin
        stage_d[0] = in;
        for (int k = 1; k < PIPE_DEPTH; k++) stage_d[k] = stage_q[k-1];
      end
    end

    // Separate hierarchy names let timing constraints target the fixed chains.
    if (RETIME_STATUS == 0) begin : g_no_retime
      always_ff @(posedge clk) stage_q <= stage_d;
    end else begin : g_retime
      always_ff @(posedge clk) stage_q <= stage_d;
    end

    assign out = stage_q[PIPE_DEPTH-1];
  end

endmodule

module dff2 #(
  parameter int WIDTH         = 1,
  parameter int PIPE_DEPTH    = 1,
  parameter int RETIME_STATUS = 0,
  parameter int ARRAY_SIZE    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [ARRAY_SIZE-1:0][WIDTH-1:0] in,
  output logic [ARRAY_SIZE-1:0][WIDTH-1:0] out
);

  // Elements share controls, so one flattened chain keeps every index aligned.
  dff #(
    .WIDTH        (WIDTH * ARRAY_SIZE),
    .PIPE_DEPTH   (PIPE_DEPTH),
    .RETIME_STATUS(RETIME_STATUS)
  ) u_flat (
    .clk(clk),
    .rst(rst),
    .en (en),
    .in (in),
    .out(out)
  );

endmodule

module dff3 #(
  parameter int WIDTH         = 1,
  parameter int PIPE_DEPTH    = 1,
  parameter int RETIME_STATUS = 0,
  parameter int ARRAY_SIZE1   = 1,
  parameter int ARRAY_SIZE2   = 1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               en,
  input  logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] in,
  output logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] out
);

  dff #(
    .WIDTH        (WIDTH * ARRAY_SIZE1 * ARRAY_SIZE2),
    .PIPE_DEPTH   (PIPE_DEPTH),
    .RETIME_STATUS(RETIME_STATUS)
  ) u_flat (
    .clk(clk),
    .rst(rst),
    .en (en),
    .in (in),
    .out(out)
  );

endmodule

module dff_pipe_family #(
  parameter int WIDTH       = 32,
  parameter int MAT_WIDTH   = 24,
  parameter int PIPE_DEPTH  = 3,
  parameter int ARRAY_SIZE  = 3,
  parameter int ARRAY_SIZE1 = 3,
  parameter int ARRAY_SIZE2 = 3
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   en,
  input  logic [WIDTH-1:0]                                       in,
  output logic [WIDTH-1:0]                                       out,
  output logic [WIDTH-1:0]                                       short_out,
  input  logic [ARRAY_SIZE-1:0][WIDTH-1:0]                       arr_in,
  output logic [ARRAY_SIZE-1:0][WIDTH-1:0]                       arr_out,
  output logic [ARRAY_SIZE-1:0][WIDTH-1:0]                       arr_thru_out,
  input  logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][MAT_WIDTH-1:0] mat_in,
  output logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][MAT_WIDTH-1:0] mat_out,
  output logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][MAT_WIDTH-1:0] mat_short_out
);

  dff #(.WIDTH(WIDTH), .PIPE_DEPTH(PIPE_DEPTH)) u_dff (
    .clk(clk), .rst(rst), .en(en), .in(in), .out(out)
  );

  // One stage shorter: its output leads out by exactly one enabled cycle.
  dff #(.WIDTH(WIDTH), .PIPE_DEPTH(PIPE_DEPTH - 1), .RETIME_STATUS(1)) u_dff_short (
    .clk(clk), .rst(rst), .en(en), .in(in), .out(short_out)
  );

  dff2 #(.WIDTH(WIDTH), .PIPE_DEPTH(PIPE_DEPTH), .ARRAY_SIZE(ARRAY_SIZE)) u_dff2 (
    .clk(clk), .rst(rst), .en(en), .in(arr_in), .out(arr_out)
  );

  dff2 #(.WIDTH(WIDTH), .PIPE_DEPTH(0), .ARRAY_SIZE(ARRAY_SIZE)) u_dff2_thru (
    .clk(clk), .rst(rst), .en(en), .in(arr_in), .out(arr_thru_out)
  );

  dff3 #(
    .WIDTH(MAT_WIDTH), .PIPE_DEPTH(PIPE_DEPTH),
    .ARRAY_SIZE1(ARRAY_SIZE1), .ARRAY_SIZE2(ARRAY_SIZE2)
  ) u_dff3 (
    .clk(clk), .rst(rst), .en(en), .in(mat_in), .out(mat_out)
  );

  dff3 #(
    .WIDTH(MAT_WIDTH), .PIPE_DEPTH(PIPE_DEPTH - 1),
    .ARRAY_SIZE1(ARRAY_SIZE1), .ARRAY_SIZE2(ARRAY_SIZE2)
  ) u_dff3_short (
    .clk(clk), .rst(rst), .en(en), .in(mat_in), .out(mat_short_out)
  );

endmodule

// File: tb/tb_dff_pipe_family.sv
// Bench for dff_pipe_family: directed vector table, hand sequences for array
// indexing and zero depth, then random traffic against a sample-history model.

module tb_dff_pipe_family;

  typedef logic [2:0][31:0]       arr_t;
  typedef logic [2:0][2:0][23:0]  mat_t;

  typedef struct packed {
    logic [31:0] s;
    arr_t        a;
    mat_t        m;
  } samp_t;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] in;
    logic [31:0] exp_out;
    logic [31:0] exp_short;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] in;
  logic [31:0] out;
  logic [31:0] short_out;
  arr_t        arr_in, arr_out, arr_thru_out;
  mat_t        mat_in, mat_out, mat_short_out;

  int checks   = 0;
  int failures = 0;

  // Model: most recent enabled samples since the last reset, newest first.
  samp_t hist[$];

  dff_pipe_family dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .in           (in),
    .out          (out),
    .short_out    (short_out),
    .arr_in       (arr_in),
    .arr_out      (arr_out),
    .arr_thru_out (arr_thru_out),
    .mat_in       (mat_in),
    .mat_out      (mat_out),
    .mat_short_out(mat_short_out)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic samp_t cur_samp();
    samp_t s;
    s.s = in;
    s.a = arr_in;
    s.m = mat_in;
    return s;
  endfunction

  // Value visible at a depth-d output: the d-th newest enabled sample, or zero.
  function automatic samp_t model_at(int d);
    if (d == 0) return cur_samp();
    if (hist.size() >= d) return hist[d-1];
    return '0;
  endfunction

  function automatic mat_t pat(int c);
    mat_t m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m[i][j] = 24'(16 * i + j + c);
    m[2][1] = 24'hFFFFFF ^ 24'(c);
    return m;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: drive inputs at negedge, advance model, cross the rising edge
  task automatic apply(input logic r, input logic e, input logic [31:0] s,
                       input arr_t a, input mat_t m);
    rst    = r;
    en     = e;
    in     = s;
    arr_in = a;
    mat_in = m;
    if (!r) hist.delete();
    else if (e) begin
      hist.push_front(cur_samp());
      if (hist.size() > 8) void'(hist.pop_back());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    samp_t d3, d2, d0;
    d3 = model_at(3);
    d2 = model_at(2);
    d0 = model_at(0);
    check({tag, ".out"},           256'(out),           256'(d3.s));
    check({tag, ".short_out"},     256'(short_out),     256'(d2.s));
    check({tag, ".arr_out"},       256'(arr_out),       256'(d3.a));
    check({tag, ".arr_thru_out"},  256'(arr_thru_out),  256'(d0.a));
    check({tag, ".mat_out"},       256'(mat_out),       256'(d3.m));
    check({tag, ".mat_short_out"}, 256'(mat_short_out), 256'(d2.m));
  endtask

  function automatic arr_t rand_arr();
    arr_t a;
    for (int i = 0; i < 3; i++) a[i] = $urandom;
    return a;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) m[i][j] = 24'($urandom);
    return m;
  endfunction

  vec_t vecs[22];

  initial begin
    vecs[0]  = '{1, 1, 32'd1,          32'd0,          32'd0};
    vecs[1]  = '{1, 1, 32'd2,          32'd0,          32'd1};
    vecs[2]  = '{1, 1, 32'd3,          32'd1,          32'd2};
    vecs[3]  = '{1, 1, 32'd4,          32'd2,          32'd3};
    vecs[4]  = '{1, 1, 32'd5,          32'd3,          32'd4};
    vecs[5]  = '{1, 1, 32'd6,          32'd4,          32'd5};
    vecs[6]  = '{1, 0, 32'd7,          32'd4,          32'd5};
    vecs[7]  = '{1, 0, 32'd8,          32'd4,          32'd5};
    vecs[8]  = '{1, 0, 32'd9,          32'd4,          32'd5};
    vecs[9]  = '{1, 0, 32'd10,         32'd4,          32'd5};
    vecs[10] = '{1, 1, 32'd11,         32'd5,          32'd6};
    vecs[11] = '{1, 1, 32'd12,         32'd6,          32'd11};
    vecs[12] = '{1, 1, 32'hAAAA_AAAA,  32'd11,         32'd12};
    vecs[13] = '{1, 1, 32'hAAAA_AAAA,  32'd12,         32'hAAAA_AAAA};
    vecs[14] = '{1, 1, 32'hAAAA_AAAA,  32'hAAAA_AAAA,  32'hAAAA_AAAA};
    vecs[15] = '{0, 1, 32'd13,         32'd0,          32'd0};
    vecs[16] = '{1, 1, 32'd21,         32'd0,          32'd0};
    vecs[17] = '{1, 1, 32'd22,         32'd0,          32'd21};
    vecs[18] = '{1, 1, 32'd23,         32'd21,         32'd22};
    vecs[19] = '{0, 0, 32'd24,         32'd0,          32'd0};
    vecs[20] = '{1, 0, 32'd25,         32'd0,          32'd0};
    vecs[21] = '{1, 1, 32'd26,         32'd0,          32'd0};

    rst = 1'b0; en = 1'b0; in = '0; arr_in = '0; mat_in = '0;
    @(negedge clk);

    // reset state
    apply(0, 1, 32'hDEAD_BEEF, rand_arr(), rand_mat());
    apply(0, 0, 32'h1234_5678, rand_arr(), rand_mat());
    check("reset.out",       256'(out),           256'd0);
    check("reset.short",     256'(short_out),     256'd0);
    check("reset.arr",       256'(arr_out),       256'd0);
    check("reset.mat",       256'(mat_out),       256'd0);
    check("reset.mat_short", 256'(mat_short_out), 256'd0);

    // directed table: depth, stall, mid-stream reset, reset with enable low
    for (int v = 0; v < 22; v++) begin
      apply(vecs[v].rst, vecs[v].en, vecs[v].in, rand_arr(), rand_mat());
      check($sformatf("vec%0d.out", v),   256'(out),       256'(vecs[v].exp_out));
      check($sformatf("vec%0d.short", v), 256'(short_out), 256'(vecs[v].exp_short));
      check_model($sformatf("vec%0d", v));
    end

    // 2-D index integrity and bit-exact all-ones, depth 3 vs depth 2
    apply(0, 1, '0, '0, '0);
    for (int c = 0; c < 10; c++) begin
      apply(1, 1, $urandom, rand_arr(), pat(c));
      check($sformatf("mat_short.c%0d", c), 256'(mat_short_out),
            (c >= 1) ? 256'(pat(c - 1)) : 256'd0);
      check($sformatf("mat.c%0d", c), 256'(mat_out),
            (c >= 2) ? 256'(pat(c - 2)) : 256'd0);
    end

    // zero depth follows input combinationally under reset and stall
    rst = 1'b0; en = 1'b0;
    arr_in = {32'd9, 32'd8, 32'd7};
    #1;
    check("thru.rst_low", 256'(arr_thru_out), 256'({32'd9, 32'd8, 32'd7}));
    rst = 1'b1; en = 1'b1;
    arr_in = {32'd3, 32'hFFFF_FFFF, 32'd1};
    #1;
    check("thru.en_high", 256'(arr_thru_out), 256'({32'd3, 32'hFFFF_FFFF, 32'd1}));
    apply(0, 0, '0, '0, '0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
            $urandom, rand_arr(), rand_mat());
      check_model($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
